jstk_spi_master: RTL and testbench

- SPI mode-0 master for the PmodJSTK joystick, directly downstream of the 66.67 kHz clock divider.
- Runs entirely on the 100 MHz system clock. Treats the divider output as a timing source: it is synchronised and edge-detected to pace SCLK.
- Each transaction exchanges 5 bytes: it sends the LED command and collects X (10 bit), Y (10 bit) and button state.
- Presents the results as registered, atomically updated outputs to the car-control logic.

---
 rtl/jstk_pkg.sv | 15 +
 rtl/jstk_edge_sync.sv | 31 +++
 rtl/jstk_spi_master.sv | 208 ++++++++++++++++++++
 tb/tb_jstk_spi_master.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI master.
package jstk_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, FINISH, HOLD} jstk_state_e;

   localparam int unsigned NBYTES          = 5;
   localparam logic [5:0]  JSTK_CMD_PREFIX = 6'b100000;

   // Bit fields taken from the high-order position bytes and the button byte.
   localparam int unsigned X_HI_MSB = 1;
   localparam int unsigned X_HI_LSB = 0;
   localparam int unsigned BTN_MSB  = 2;
   localparam int unsigned BTN_LSB  = 0;

endpackage

// File: rtl/jstk_edge_sync.sv
// Multi-stage synchroniser followed by a one-CLK rise/fall detector.
module jstk_edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic D,
   output logic RISE,
   output logic FALL
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_s;

   assign sync_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], D};
         prev_q <= sync_s;
      end
   end

   assign RISE = sync_s & ~prev_q;
   assign FALL = ~sync_s & prev_q;

endmodule

// File: rtl/jstk_spi_master.sv
// SPI mode-0 master for the PmodJSTK: sends the LED command, collects X/Y/buttons.
module jstk_spi_master #(
   parameter int unsigned NBYTES      = jstk_pkg::NBYTES,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SCLK_SRC,
   input  logic       START,
   input  logic [1:0] LED,
   input  logic       MISO,
   output logic       SS,
   output logic       SCLK,
   output logic       MOSI,
   output logic       BUSY,
   output logic       DONE,
   output logic [9:0] X,
   output logic [9:0] Y,
   output logic [2:0] BTN
);

   import jstk_pkg::*;

   jstk_state_e state_q, state_d;
   logic [7:0]  tx_q, tx_d, rx_q, rx_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]  byte_cnt_q, byte_cnt_d;
   logic        seen_rise_q, seen_rise_d;
   logic        ss_q, ss_d, sclk_q, sclk_d, mosi_q, mosi_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic [7:0]  x_lo_q, x_lo_d, y_lo_q, y_lo_d;
   logic [1:0]  x_hi_q, x_hi_d, y_hi_q, y_hi_d;
   logic [2:0]  btn_raw_q, btn_raw_d;
   logic [9:0]  x_q, x_d, y_q, y_d;
   logic [2:0]  btn_q, btn_d;
   logic [SYNC_STAGES-1:0] miso_sync_q;
   logic        miso_s, rise_tk, fall_tk;

   jstk_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sclk_sync (
      .CLK (CLK),
      .RST (RST),
      .D   (SCLK_SRC),
      .RISE(rise_tk),
      .FALL(fall_tk)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) miso_sync_q <= '0;
      else     miso_sync_q <= {miso_sync_q[SYNC_STAGES-2:0], MISO};
   end
   assign miso_s = miso_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d     = state_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      seen_rise_d = seen_rise_q;
      ss_d        = ss_q;
      sclk_d      = sclk_q;
      mosi_d      = mosi_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      x_lo_d      = x_lo_q;
      x_hi_d      = x_hi_q;
      y_lo_d      = y_lo_q;
      y_hi_d      = y_hi_q;
      btn_raw_d   = btn_raw_q;
      x_d         = x_q;
      y_d         = y_q;
      btn_d       = btn_q;
      unique case (state_q)
         IDLE: begin
            ss_d   = 1'b1;
            sclk_d = 1'b0;
            mosi_d = 1'b0;
            if (START) begin
               tx_d       = {JSTK_CMD_PREFIX, LED};
               mosi_d     = LED[1] & 1'b0 | JSTK_CMD_PREFIX[5];
               ss_d       = 1'b0;
               busy_d     = 1'b1;
               byte_cnt_d = '0;
               state_d    = SETUP;
            end
         end
         SETUP: begin
            if (rise_tk) begin
               seen_rise_d = 1'b1;
            end else if (fall_tk && seen_rise_q) begin
               seen_rise_d = 1'b0;
               bit_cnt_d   = '0;
               state_d     = XFER;
            end
         end
         XFER: begin
            if (rise_tk) begin
               sclk_d    = 1'b1;
               rx_d      = {rx_q[6:0], miso_s};
               bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (fall_tk) begin
               sclk_d = 1'b0;
               if (bit_cnt_q < 4'd8) begin
                  mosi_d = tx_q[6];
                  tx_d   = {tx_q[6:0], 1'b0};
               end else begin
                  case (byte_cnt_q)
                     3'd0:    x_lo_d    = rx_q;
                     3'd1:    x_hi_d    = rx_q[X_HI_MSB:X_HI_LSB];
                     3'd2:    y_lo_d    = rx_q;
                     3'd3:    y_hi_d    = rx_q[X_HI_MSB:X_HI_LSB];
                     default: btn_raw_d = rx_q[BTN_MSB:BTN_LSB];
                  endcase
                  state_d = (byte_cnt_q == 3'(NBYTES - 1)) ? FINISH : GAP;
               end
            end
         end
         GAP: begin
            sclk_d = 1'b0;
            if (rise_tk) begin
               seen_rise_d = 1'b1;
            end else if (fall_tk && seen_rise_q) begin
               seen_rise_d = 1'b0;
               byte_cnt_d  = byte_cnt_q + 3'd1;
               tx_d        = 8'h00;
               mosi_d      = 1'b0;
               bit_cnt_d   = '0;
               state_d     = XFER;
            end
         end
         FINISH: begin
            ss_d    = 1'b1;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            x_d     = {x_hi_q, x_lo_q};
            y_d     = {y_hi_q, y_lo_q};
            btn_d   = btn_raw_q;
            state_d = HOLD;
         end
         HOLD: begin
            if (rise_tk) begin
               seen_rise_d = 1'b1;
            end else if (fall_tk && seen_rise_q) begin
               seen_rise_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         tx_q        <= '0;
         rx_q        <= '0;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         seen_rise_q <= 1'b0;
         ss_q        <= 1'b1;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         x_lo_q      <= '0;
         x_hi_q      <= '0;
         y_lo_q      <= '0;
         y_hi_q      <= '0;
         btn_raw_q   <= '0;
         x_q         <= '0;
         y_q         <= '0;
         btn_q       <= '0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         seen_rise_q <= seen_rise_d;
         ss_q        <= ss_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         x_lo_q      <= x_lo_d;
         x_hi_q      <= x_hi_d;
         y_lo_q      <= y_lo_d;
         y_hi_q      <= y_hi_d;
         btn_raw_q   <= btn_raw_d;
         x_q         <= x_d;
         y_q         <= y_d;
         btn_q       <= btn_d;
      end
   end

   assign SS   = ss_q;
   assign SCLK = sclk_q;
   assign MOSI = mosi_q;
   assign BUSY = busy_q;
   assign DONE = done_q;
   assign X    = x_q;
   assign Y    = y_q;
   assign BTN  = btn_q;

endmodule

// File: tb/tb_jstk_spi_master.sv
// Self-checking bench: joystick slave model plus protocol-level reference checks.
module tb_jstk_spi_master;

   logic       CLK = 1'b0, RST = 1'b1, SCLK_SRC = 1'b0, START = 1'b0, MISO = 1'b0;
   logic [1:0] LED = 2'b00;
   logic       SS, SCLK, MOSI, BUSY, DONE;
   logic [9:0] X, Y;
   logic [2:0] BTN;

   int compared = 0, mismatched = 0;
   bit freeze = 1'b0;

   logic [7:0] sb [5];
   logic [7:0] mosi_got [5];
   int cyc = 0, ss_falls = 0, ss_fall_cyc = 0, rise_cnt = 0, bit_idx = 0, last_fall = 0;
   int setup_cyc = 0, min_gap = 0, mosi_bad = 0, done_cnt = 0, done_cyc = 0, xy_glitch = 0;
   int done_base = 0;
   logic prev_ss = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_rst = 1'b1;
   logic [22:0] prev_xyb = '0;

   jstk_spi_master dut (
      .CLK     (CLK),
      .RST     (RST),
      .SCLK_SRC(SCLK_SRC),
      .START   (START),
      .LED     (LED),
      .MISO    (MISO),
      .SS      (SS),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .BUSY    (BUSY),
      .DONE    (DONE),
      .X       (X),
      .Y       (Y),
      .BTN     (BTN)
   );

   always #5 CLK = ~CLK;

   // Divider stand-in: toggles every 10 CLK unless frozen.
   initial begin
      int cnt = 0;
      forever begin
         @(posedge CLK);
         #1;
         if (!freeze) begin
            cnt++;
            if (cnt == 10) begin
               cnt = 0;
               SCLK_SRC = ~SCLK_SRC;
            end
         end
      end
   end

   // Joystick slave model and bus monitor, sampled on the falling CLK edge.
   always @(negedge CLK) begin
      cyc++;
      if (prev_ss && !SS) begin
         ss_falls++;
         ss_fall_cyc = cyc;
         rise_cnt = 0;
         bit_idx = 0;
         min_gap = 100000;
         mosi_bad = 0;
         setup_cyc = 0;
         for (int i = 0; i < 5; i++) mosi_got[i] = 8'h00;
         MISO = sb[0][7];
      end
      if (!prev_sclk && SCLK) begin
         if (MOSI !== prev_mosi) mosi_bad++;
         if (rise_cnt == 0) setup_cyc = cyc - ss_fall_cyc;
         else if (rise_cnt % 8 == 0 && cyc - last_fall < min_gap) min_gap = cyc - last_fall;
         if (rise_cnt < 40) mosi_got[rise_cnt / 8][7 - (rise_cnt % 8)] = MOSI;
         rise_cnt++;
      end else if (prev_sclk && SCLK && MOSI !== prev_mosi) begin
         mosi_bad++;
      end
      if (prev_sclk && !SCLK) begin
         last_fall = cyc;
         bit_idx++;
         if (!SS && bit_idx < 40) MISO = sb[bit_idx / 8][7 - (bit_idx % 8)];
      end
      if (DONE) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (!RST && !prev_rst && !DONE && {X, Y, BTN} !== prev_xyb) xy_glitch++;
      prev_ss   = SS;
      prev_sclk = SCLK;
      prev_mosi = MOSI;
      prev_rst  = RST;
      prev_xyb  = {X, Y, BTN};
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic randomize_slave();
      for (int i = 0; i < 5; i++) sb[i] = 8'($urandom_range(0, 255));
      LED = 2'($urandom_range(0, 3));
   endtask

   task automatic start_txn(input string tag, input bit keep);
      bit ok = 1'b0;
      done_base = done_cnt;
      START = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         tick();
         ok = BUSY;
      end
      chk({tag, "_accept"}, 32'(ok), 32'd1);
      if (!keep) START = 1'b0;
   endtask

   task automatic wait_rises(input string tag, input int n);
      bit ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         tick();
         ok = (rise_cnt >= n);
      end
      chk({tag, "_reach"}, 32'(ok), 32'd1);
   endtask

   task automatic wait_done(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         tick();
         ok = (done_cnt != done_base);
      end
      chk({tag, "_done_seen"}, 32'(ok), 32'd1);
      repeat (3) tick();
   endtask

   // Reference: expected results from the protocol rules, for the current sb/LED.
   task automatic check_txn(input string tag, input int extra);
      int exp_x, exp_y, exp_btn, dur;
      exp_x   = (int'(sb[1]) % 4) * 256 + int'(sb[0]);
      exp_y   = (int'(sb[3]) % 4) * 256 + int'(sb[2]);
      exp_btn = int'(sb[4]) % 8;
      dur     = done_cyc - ss_fall_cyc;
      chk({tag, "_x"}, 32'(X), 32'(exp_x));
      chk({tag, "_y"}, 32'(Y), 32'(exp_y));
      chk({tag, "_btn"}, 32'(BTN), 32'(exp_btn));
      chk({tag, "_mosi0"}, 32'(mosi_got[0]), 32'(128 + int'(LED)));
      for (int i = 1; i < 5; i++) chk($sformatf("%s_mosi%0d", tag, i), 32'(mosi_got[i]), 32'd0);
      chk({tag, "_rises"}, 32'(rise_cnt), 32'd40);
      chk({tag, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
      chk({tag, "_setup_ge_period"}, 32'(setup_cyc >= 20), 32'd1);
      chk({tag, "_gap_ge_period"}, 32'(min_gap >= 20), 32'd1);
      chk({tag, "_mosi_stable"}, 32'(mosi_bad), 32'd0);
      chk({tag, "_duration"}, 32'(dur >= 860 + extra && dur <= 940 + extra), 32'd1);
      chk({tag, "_ss_high"}, 32'(SS), 32'd1);
   endtask

   initial begin
      int f0, delta;

      // Reset state.
      repeat (3) tick();
      chk("rst_ss", 32'(SS), 32'd1);
      chk("rst_sclk", 32'(SCLK), 32'd0);
      chk("rst_mosi", 32'(MOSI), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_xyb", 32'({X, Y, BTN}), 32'd0);
      RST = 1'b0;
      repeat (5) tick();

      // Reset in the middle of byte 2, bit 3.
      randomize_slave();
      start_txn("midrst", 1'b0);
      wait_rises("midrst", 19);
      RST = 1'b1;
      tick();
      chk("midrst_ss", 32'(SS), 32'd1);
      chk("midrst_sclk", 32'(SCLK), 32'd0);
      chk("midrst_busy", 32'(BUSY), 32'd0);
      chk("midrst_xyb", 32'({X, Y, BTN}), 32'd0);
      repeat (3) tick();
      RST = 1'b0;
      repeat (1200) tick();
      chk("midrst_no_done", 32'(done_cnt), 32'd0);
      chk("midrst_idle", 32'({SS, BUSY}), 32'b10);

      // Directed transaction, with a stray START during byte 1.
      sb[0] = 8'hA5; sb[1] = 8'h02; sb[2] = 8'h3C; sb[3] = 8'h01; sb[4] = 8'h05;
      LED = 2'b11;
      f0 = ss_falls;
      start_txn("dir", 1'b0);
      wait_rises("dir_byte1", 10);
      START = 1'b1;
      repeat (5) tick();
      START = 1'b0;
      wait_done("dir");
      check_txn("dir", 0);
      chk("dir_x_abs", 32'(X), 32'h2A5);
      chk("dir_y_abs", 32'(Y), 32'h13C);
      chk("dir_btn_abs", 32'(BTN), 32'b101);
      repeat (60) tick();
      chk("dir_no_requeue", 32'(ss_falls - f0), 32'd1);
      chk("dir_busy_off", 32'(BUSY), 32'd0);

      // Randomised transactions.
      for (int t = 0; t < 4; t++) begin
         randomize_slave();
         start_txn($sformatf("rnd%0d", t), 1'b0);
         wait_done($sformatf("rnd%0d", t));
         check_txn($sformatf("rnd%0d", t), 0);
         repeat (40) tick();
      end

      // SCLK_SRC frozen during the first inter-byte gap.
      randomize_slave();
      start_txn("frz", 1'b0);
      wait_rises("frz", 8);
      for (int i = 0; i < 40 && SCLK; i++) tick();
      freeze = 1'b1;
      repeat (500) tick();
      chk("frz_ss", 32'(SS), 32'd0);
      chk("frz_sclk", 32'(SCLK), 32'd0);
      chk("frz_rises", 32'(rise_cnt), 32'd8);
      chk("frz_busy", 32'(BUSY), 32'd1);
      freeze = 1'b0;
      wait_done("frz");
      check_txn("frz", 500);
      repeat (40) tick();

      // START held high: back-to-back transactions.
      randomize_slave();
      f0 = ss_falls;
      start_txn("b2b_a", 1'b1);
      wait_done("b2b_a");
      check_txn("b2b_a", 0);
      for (int i = 0; i < 200 && ss_falls == f0 + 1; i++) tick();
      delta = ss_fall_cyc - done_cyc;
      chk("b2b_restart", 32'(ss_falls - f0), 32'd2);
      chk("b2b_hold_len", 32'(delta >= 20 && delta <= 21), 32'd1);
      START = 1'b0;
      done_base = done_cnt;
      wait_done("b2b_b");
      check_txn("b2b_b", 0);
      repeat (60) tick();
      chk("b2b_stop", 32'(ss_falls - f0), 32'd2);

      chk("xyb_only_on_done", 32'(xy_glitch), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
